nios_system_irq_ctrl: RTL and testbench



---
 rtl/nios_system_irq_ctrl_pkg.sv | 22 ++
 rtl/nios_system_irq_ctrl_if.sv | 19 +
 rtl/nios_system_irq_ctrl_prio_enc.sv | 24 ++
 rtl/nios_system_irq_ctrl.sv | 158 +++++++++++++++
 tb/tb_nios_system_irq_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_irq_ctrl_pkg.sv
// Shared constants and types for the Nios II interrupt controller:
// register addresses, FSM state encoding, claim word layout.
package nios_irq_ctrl_pkg;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_CLAIM   = 3'd3;
    localparam logic [2:0] ADDR_SWTRIG  = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;
    localparam logic [2:0] ADDR_COUNT   = 3'd6;

    localparam int ID_W            = 4;
    localparam int CLAIM_VALID_BIT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/nios_system_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt controller register file.
interface nios_system_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_irq_ctrl_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module nios_irq_ctrl_prio_enc
    import nios_irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/nios_system_irq_ctrl.sv
// Nios II interrupt controller: per-source mask and edge/level select,
// fixed lowest-index priority, claim/complete handshake over Avalon-MM.
// Optional claim counter at address 6 when NIOS_IRQ_CTRL_COUNT_EN is defined.
module nios_system_irq_ctrl
    import nios_irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_IRQ-1:0]             irq_in,
    nios_system_irq_ctrl_if.slave        bus,
    output logic                         irq_out
);

    logic [N_IRQ-1:0] irq_q, irq_qq;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] edge_q, edge_d;
    state_e           state_q, state_d;
    logic [ID_W-1:0]  in_service_q, in_service_d;
    logic [15:0]      readdata_q, readdata_d;
    logic             irq_out_q, irq_out_d;

    logic             rd, wr;
    logic [N_IRQ-1:0] wdata_n, edge_ev, active, claim_clr, edge_set, edge_clr;
    logic             win_valid, claim_ok, complete_ok;
    logic [ID_W-1:0]  win_id;

    function automatic logic [15:0] zext(input logic [N_IRQ-1:0] v);
        logic [15:0] r;
        r            = '0;
        r[N_IRQ-1:0] = v;
        return r;
    endfunction

    assign rd      = bus.chipselect & ~bus.read_n;
    assign wr      = bus.chipselect & ~bus.write_n;
    assign wdata_n = bus.writedata[N_IRQ-1:0];
    assign edge_ev = irq_q & ~irq_qq;
    assign active  = pending_q & mask_q;

    nios_irq_ctrl_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
        .req   (active),
        .valid (win_valid),
        .id    (win_id)
    );

    assign claim_ok    = rd && (bus.address == ADDR_CLAIM) && (state_q == PEND) && win_valid;
    assign complete_ok = wr && (bus.address == ADDR_CLAIM) && (state_q == SERVICE)
                         && (bus.writedata[ID_W-1:0] == in_service_q);

    // Pending/mask/edge next state; for edge bits set beats clear.
    always_comb begin
        for (int i = 0; i < N_IRQ; i++) begin
            claim_clr[i] = claim_ok && (win_id == ID_W'(i));
        end
        edge_set  = edge_ev | ((wr && bus.address == ADDR_SWTRIG) ? wdata_n : '0);
        edge_clr  = ((wr && bus.address == ADDR_PENDING) ? wdata_n : '0) | claim_clr;
        pending_d = (edge_q & ((pending_q & ~edge_clr) | edge_set)) | (~edge_q & irq_q);
        mask_d    = (wr && bus.address == ADDR_MASK) ? wdata_n : mask_q;
        edge_d    = (wr && bus.address == ADDR_EDGE) ? wdata_n : edge_q;
    end

    // Claim/complete state machine; irq_out follows the next state.
    always_comb begin
        state_d      = state_q;
        in_service_d = in_service_q;
        case (state_q)
            IDLE: begin
                if (|active) state_d = PEND;
            end
            PEND: begin
                if (!(|active)) begin
                    state_d = IDLE;
                end else if (claim_ok) begin
                    state_d      = SERVICE;
                    in_service_d = win_id;
                end
            end
            SERVICE: begin
                if (complete_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_out_d = (state_d == PEND);
    end

`ifdef NIOS_IRQ_CTRL_COUNT_EN
    logic [15:0] count_q, count_d;

    // Claim counter; a write to its address clears it and beats an increment.
    always_comb begin
        if (wr && bus.address == ADDR_COUNT) count_d = '0;
        else if (claim_ok)                   count_d = count_q + 16'd1;
        else                                 count_d = count_q;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
`endif

    // Read mux, evaluated every cycle; CLAIM shows the winner only while in PEND.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_PENDING: readdata_d = zext(pending_q);
            ADDR_MASK:    readdata_d = zext(mask_q);
            ADDR_EDGE:    readdata_d = zext(edge_q);
            ADDR_CLAIM: begin
                if (state_q == PEND && win_valid) begin
                    readdata_d[CLAIM_VALID_BIT] = 1'b1;
                    readdata_d[ID_W-1:0]        = win_id;
                end
            end
            ADDR_STATUS: begin
                readdata_d[1:0] = state_q;
                readdata_d[7:4] = in_service_q;
            end
`ifdef NIOS_IRQ_CTRL_COUNT_EN
            ADDR_COUNT:   readdata_d = count_q;
`endif
            default:      readdata_d = '0;
        endcase
    end

    // All controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q        <= '0;
            irq_qq       <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            state_q      <= IDLE;
            in_service_q <= '0;
            readdata_q   <= '0;
            irq_out_q    <= 1'b0;
        end else begin
            irq_q        <= irq_in;
            irq_qq       <= irq_q;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            edge_q       <= edge_d;
            state_q      <= state_d;
            in_service_q <= in_service_d;
            readdata_q   <= readdata_d;
            irq_out_q    <= irq_out_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq_out      = irq_out_q;

endmodule

// File: tb/tb_nios_system_irq_ctrl.sv
// Directed bench for nios_system_irq_ctrl with hand-computed expectations.
module tb_nios_system_irq_ctrl;
    import nios_irq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       irq_out;
    int         checks   = 0;
    int         failures = 0;

    nios_system_irq_ctrl_if bus ();

    nios_system_irq_ctrl #(.N_IRQ(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .bus     (bus.slave),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {15'b0, irq_out}, {15'b0, exp});
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_check(input logic [2:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        check(tag, bus.readdata, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        irq_in         = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        chk_irq("rst_irq_out", 1'b0);
        check("rst_readdata", bus.readdata, 16'h0000);
        reset = 1'b0;
        rd_check(ADDR_STATUS, 16'h0000, "rst_status");
        rd_check(ADDR_MASK,   16'h0000, "rst_mask");

        // Level source on bit 0: three-clock latency, claim, complete.
        bus_wr(ADDR_MASK, 16'h0001);
        bus_wr(ADDR_EDGE, 16'h0000);
        irq_in = 8'h01;
        @(negedge clk);
        @(negedge clk);
        chk_irq("lvl_irq_e2", 1'b0);
        @(negedge clk);
        chk_irq("lvl_irq_e3", 1'b1);
        rd_check(ADDR_CLAIM, 16'h8000, "lvl_claim");
        chk_irq("lvl_irq_svc", 1'b0);
        irq_in = 8'h00;
        rd_check(ADDR_STATUS, 16'h0002, "lvl_status_svc");
        bus_wr(ADDR_CLAIM, 16'h0000);
        repeat (3) @(negedge clk);
        chk_irq("lvl_irq_done", 1'b0);
        rd_check(ADDR_STATUS, 16'h0000, "lvl_status_idle");

        // Priority between two simultaneous edge sources.
        bus_wr(ADDR_MASK, 16'h00FF);
        bus_wr(ADDR_EDGE, 16'h00FF);
        irq_in = 8'h24;
        @(negedge clk);
        irq_in = 8'h00;
        repeat (3) @(negedge clk);
        chk_irq("pri_irq", 1'b1);
        rd_check(ADDR_CLAIM, 16'h8002, "pri_claim1");
        bus_wr(ADDR_CLAIM, 16'h0002);
        rd_check(ADDR_CLAIM, 16'h8005, "pri_claim2");
        rd_check(ADDR_PENDING, 16'h0000, "pri_pending");
        rd_check(ADDR_STATUS, 16'h0052, "pri_status");
        bus_wr(ADDR_CLAIM, 16'h0005);

        // Hold-off while in service, wrong-id complete ignored.
        irq_in = 8'h08;
        @(negedge clk);
        irq_in = 8'h00;
        repeat (3) @(negedge clk);
        rd_check(ADDR_CLAIM, 16'h8003, "svc_claim3");
        irq_in = 8'h02;
        @(negedge clk);
        irq_in = 8'h00;
        repeat (3) @(negedge clk);
        chk_irq("svc_holdoff", 1'b0);
        rd_check(ADDR_CLAIM, 16'h0000, "svc_claim_again");
        rd_check(ADDR_PENDING, 16'h0002, "svc_pending");
        bus_wr(ADDR_CLAIM, 16'h0001);
        rd_check(ADDR_STATUS, 16'h0032, "svc_bad_complete");
        bus_wr(ADDR_CLAIM, 16'h0003);
        chk_irq("svc_done_idle", 1'b0);
        @(negedge clk);
        chk_irq("svc_reraise", 1'b1);
        rd_check(ADDR_CLAIM, 16'h8001, "svc_claim1");
        bus_wr(ADDR_CLAIM, 16'h0001);

        // Set beats clear; SWTRIG only affects edge bits; W1C ignored on level bits.
        bus_wr(ADDR_MASK, 16'h0000);
        irq_in = 8'h10;
        bus_wr(ADDR_PENDING, 16'h0010);
        rd_check(ADDR_PENDING, 16'h0010, "sc_set_wins");
        irq_in = 8'h00;
        bus_wr(ADDR_PENDING, 16'h0010);
        rd_check(ADDR_PENDING, 16'h0000, "sc_w1c");
        bus_wr(ADDR_SWTRIG, 16'h0010);
        rd_check(ADDR_PENDING, 16'h0010, "sc_swtrig_edge");
        rd_check(ADDR_SWTRIG, 16'h0000, "sc_swtrig_rd0");
        bus_wr(ADDR_PENDING, 16'h0010);
        bus_wr(ADDR_EDGE, 16'h00EF);
        bus_wr(ADDR_SWTRIG, 16'h0010);
        rd_check(ADDR_PENDING, 16'h0000, "sc_swtrig_level");
        irq_in = 8'h10;
        repeat (2) @(negedge clk);
        bus_wr(ADDR_PENDING, 16'h0010);
        rd_check(ADDR_PENDING, 16'h0010, "sc_w1c_level");
        irq_in = 8'h00;
        bus_wr(ADDR_EDGE, 16'h00FF);
        rd_check(ADDR_PENDING, 16'h0000, "sc_level_cleared");

        // Masking the active source drops irq_out one cycle after the write.
        bus_wr(ADDR_MASK, 16'h0040);
        bus_wr(ADDR_SWTRIG, 16'h0040);
        @(negedge clk);
        chk_irq("mk_irq", 1'b1);
        bus_wr(ADDR_MASK, 16'h0000);
        chk_irq("mk_irq_landed", 1'b1);
        @(negedge clk);
        chk_irq("mk_irq_drop", 1'b0);

        // Reset in SERVICE.
        bus_wr(ADDR_MASK, 16'h0040);
        @(negedge clk);
        rd_check(ADDR_CLAIM, 16'h8006, "rs_claim");
        rd_check(ADDR_STATUS, 16'h0062, "rs_status");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_irq("rs_irq_out", 1'b0);
        check("rs_readdata", bus.readdata, 16'h0000);
        rd_check(ADDR_STATUS,  16'h0000, "rs_status_after");
        rd_check(ADDR_MASK,    16'h0000, "rs_mask_after");
        rd_check(ADDR_PENDING, 16'h0000, "rs_pending_after");

`ifdef NIOS_IRQ_CTRL_COUNT_EN
        bus_wr(ADDR_EDGE, 16'h00FF);
        bus_wr(ADDR_MASK, 16'h0001);
        bus_wr(ADDR_SWTRIG, 16'h0001);
        @(negedge clk);
        rd_check(ADDR_CLAIM, 16'h8000, "cnt_claim1");
        bus_wr(ADDR_CLAIM, 16'h0000);
        rd_check(ADDR_COUNT, 16'h0001, "cnt_one");
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        bus_wr(ADDR_SWTRIG, 16'h0001);
        @(negedge clk);
        rd_check(ADDR_CLAIM, 16'h8000, "cnt_claim2");
        bus_wr(ADDR_CLAIM, 16'h0000);
        rd_check(ADDR_COUNT, 16'h0000, "cnt_wrap");
`else
        rd_check(ADDR_COUNT, 16'h0000, "cnt_absent");
        bus_wr(ADDR_COUNT, 16'h1234);
        rd_check(ADDR_COUNT, 16'h0000, "cnt_absent_wr");
`endif
        rd_check(3'd7, 16'h0000, "reserved_rd0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
